tb_stream_harness: RTL and testbench
====================================

// Module: tb_stream_harness
// PURPOSE
//  Parametrised multi-channel stream harness for the UVM TB: NUM_CH valid/ready source channels,
//  each buffered by a DEPTH-entry FIFO, merged round-robin onto one registered valid/ready sink
//  tagged with channel id. Adds per-channel fill levels, synchronous flush and a stall watchdog.
//  Sits between agent drivers and the DUT stream port inside the harness.
// PARAMETERS
//  NUM_CH   4     number of input channels, >=1
//  DATA_W   32    payload width, >=1
//  DEPTH    8     per-channel FIFO entries, power of 2, >=2
//  TIMEOUT  1024  stall cycles before watchdog fires; 0 disables watchdog
// PORTS
//  clk        in   1                      clock, all logic on posedge
//  rst        in   1                      asynchronous reset, active-high
//  flush      in   1                      synchronous clear of all buffered data
//  in_valid   in   NUM_CH                 per-channel source valid
//  in_ready   out  NUM_CH                 per-channel source ready
//  in_data    in   NUM_CH*DATA_W          channel i payload at [i*DATA_W +: DATA_W]
//  out_valid  out  1                      sink valid (registered)
//  out_ready  in   1                      sink ready
//  out_data   out  DATA_W                 sink payload (registered)
//  out_ch     out  CH_W                   source channel of out_data (registered)
//  ch_level   out  NUM_CH*LVL_W           FIFO occupancy per channel, 0..DEPTH
//  timeout    out  1                      sticky watchdog flag
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFOs empty, rr pointer 0, watchdog 0; out_valid=0,
//    out_data=0, out_ch=0, ch_level=0, timeout=0; in_ready forced 0 while rst high.
//  - in_ready[i] = !full_i && !rst; derived from state only, never from in_valid.
//    Push on in_valid[i]&&in_ready[i]. Full FIFO: ready low, no push, no overwrite.
//  - Output register "free" when !out_valid or (out_valid&&out_ready). When free, arbiter
//    picks first non-empty channel scanning from (last_grant+1) mod NUM_CH; that FIFO pops
//    and the beat loads into out_* on the same edge; last_grant updates. None non-empty and
//    handshake occurs -> out_valid drops to 0.
//  - Latency: beat pushed at edge k into idle harness -> out_valid=1 after edge k+1.
//    Sustained throughput 1 beat/cycle; fairness: no channel waits > NUM_CH-1 grants.
//  - Push and pop on same FIFO same cycle allowed (level unchanged); pop only of stored data,
//    no bypass. ch_level counts FIFO entries only, excludes the output register.
//  - out_data/out_ch stable while out_valid&&!out_ready; out_valid never drops without handshake
//    (except rst/flush).
//  - flush: next edge empties all FIFOs, out_valid=0, rr pointer 0, watchdog count 0; pushes
//    in the flush cycle are discarded; timeout NOT cleared (only rst clears it).
//  - Watchdog: counter +1 each cycle out_valid&&!out_ready, cleared on handshake or !out_valid;
//    saturates; when count reaches TIMEOUT, timeout=1 next edge and stays set.
//  - Pointers wrap mod DEPTH with extra MSB for full/empty distinction.
// STRUCTURE
//  - tb_harness_pkg: CH_W=max(1,$clog2(NUM_CH)), LVL_W=$clog2(DEPTH)+1 helper functions,
//    beat_t struct {data, ch} typedef, rr_next() arbitration function.
//  - One sub-module tb_harness_fifo (DATA_W, DEPTH): push/pop/full/empty/level/flush,
//    instantiated NUM_CH times via generate; arbiter, output register, watchdog in top.
// TESTING
//  1 Reset: rst=1 mid-traffic -> all outputs 0, in_ready=0 immediately; after release ready=1.
//  2 Single beat ch2 data 0xA5A5_0002 into idle -> out_valid after 2 edges, out_ch=2, level 0.
//  3 All 4 ch push 8 beats, out_ready=1 -> ch order 0,1,2,3 repeating, 32 beats, no loss.
//  4 out_ready=0, push 8 beats ch1 -> ch_level[1]=7 (one in out reg), then 8, in_ready[1]=0.
//  5 TIMEOUT=16, hold out_ready=0 with out_valid=1 -> timeout=1 after 16 stall cycles,
//    remains 1 after out_ready=1 and after flush.
//  6 flush with 5 beats queued -> next cycle out_valid=0, all levels 0, in_ready all 1.

Source files
------------

// File: rtl/tb_harness_pkg.sv
// Shared widths, the beat record and the round-robin step used by the stream harness.
// Channel-id and fill-level widths are derived from the module parameters through these functions.
package tb_harness_pkg;

    localparam int DFLT_NUM_CH = 4;
    localparam int DFLT_DATA_W = 32;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DFLT_CH_W = ch_width(DFLT_NUM_CH);

    typedef struct packed {
        logic [DFLT_DATA_W-1:0] data;
        logic [DFLT_CH_W-1:0]   ch;
    } beat_t;

    // Channel after cur, wrapping at num_ch.
    function automatic int rr_next(input int cur, input int num_ch);
        return (cur + 1 >= num_ch) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/tb_harness_fifo.sv
// Per-channel buffer: DEPTH entries, extra pointer MSB separates full from empty.
// flush clears both pointers on the next edge.
module tb_harness_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        push_data,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr;
    logic [AW:0]       r_rd;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign empty     = (r_wr == r_rd);
    assign level     = r_wr - r_rd;
    assign pop_data  = r_mem[r_rd[AW-1:0]];
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

endmodule

// File: rtl/tb_stream_harness.sv
// NUM_CH buffered source channels merged round-robin onto one registered sink tagged with
// the channel id; per-channel fill levels, synchronous flush and a sticky stall watchdog.
module tb_stream_harness
    import tb_harness_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [NUM_CH-1:0]                     in_valid,
    output logic [NUM_CH-1:0]                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0]              in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_W-1:0]                     out_data,
    output logic [ch_width(NUM_CH)-1:0]           out_ch,
    output logic [NUM_CH*lvl_width(DEPTH)-1:0]    ch_level,
    output logic                                  timeout
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int LVL_W = lvl_width(DEPTH);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    // Handshake: a beat moves when valid && ready on a rising edge; ready never depends on
    // valid, and a raised valid holds its payload stable until that beat moves.
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [DATA_W-1:0] w_fifo_data [NUM_CH];
    logic              w_free;
    logic              w_load;
    logic              w_grant_vld;
    logic [CH_W-1:0]   w_grant_idx;
    logic              w_stall;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic [CH_W-1:0]   r_rr;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_timeout;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tb_harness_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .push      (w_push[g]),
            .pop       (w_pop[g]),
            .push_data (in_data[g*DATA_W +: DATA_W]),
            .pop_data  (w_fifo_data[g]),
            .full      (w_full[g]),
            .empty     (w_empty[g]),
            .level     (ch_level[g*LVL_W +: LVL_W])
        );
        assign in_ready[g] = !w_full[g] && !rst;
        assign w_push[g]   = in_valid[g] && in_ready[g] && !flush;
        assign w_pop[g]    = w_load && (w_grant_idx == CH_W'(g));
    end

    // r_rr holds the channel the next scan starts from, i.e. last grant + 1.
    always_comb begin
        int idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        idx         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!w_grant_vld && !w_empty[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = CH_W'(idx);
            end
        end
    end

    assign w_free  = !r_out_valid || out_ready;
    assign w_load  = w_free && w_grant_vld && !flush;
    assign w_stall = r_out_valid && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_rr        <= '0;
        end else if (w_free) begin
            r_out_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_out_data <= w_fifo_data[w_grant_idx];
                r_out_ch   <= w_grant_idx;
                r_rr       <= CH_W'(rr_next(int'(w_grant_idx), NUM_CH));
            end
        end
    end

    // Count saturates at TIMEOUT; the flag follows one edge after the count gets there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (flush || !w_stall) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != WD_MAX) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if ((TIMEOUT != 0) && (r_wd_cnt == WD_MAX)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_tb_stream_harness.sv
// Directed bench for tb_stream_harness: reset, latency, round-robin order, backpressure,
// watchdog and flush, checked against hand-computed values and an expected-beat queue.
module tb_tb_stream_harness;
    import tb_harness_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CH_W    = ch_width(NUM_CH);
    localparam int LVL_W   = lvl_width(DEPTH);
    localparam int SB_W    = CH_W + DATA_W;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH-1:0]          in_ready;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [CH_W-1:0]            out_ch;
    logic [NUM_CH*LVL_W-1:0]    ch_level;
    logic                       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [SB_W-1:0] exp_q[$];

    tb_stream_harness #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .ch_level  (ch_level),
        .timeout   (timeout)
    );

    // clock / global time limit
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [DATA_W-1:0] d);
        in_data[ch*DATA_W +: DATA_W] = d;
    endtask

    function automatic logic [LVL_W-1:0] level_of(input int ch);
        return ch_level[ch*LVL_W +: LVL_W];
    endfunction

    function automatic int level_sum();
        int s = 0;
        for (int c = 0; c < NUM_CH; c++) s += int'(level_of(c));
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] rr_beat(input int ch, input int seq);
        return DATA_W'(32'hC000_0000 + ch * 256 + seq);
    endfunction

    task automatic drain(input string tag, input int budget);
        int cyc = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (out_valid) check(tag, 64'({out_ch, out_data}), 64'(exp_q.pop_front()));
            step();
            cyc++;
        end
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(out_valid), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
        check({tag, "_odata"},  64'(out_data),  64'd0);
        check({tag, "_och"},    64'(out_ch),    64'd0);
        check({tag, "_level"},  64'(ch_level),  64'd0);
        check({tag, "_tmo"},    64'(timeout),   64'd0);
        check({tag, "_ready"},  64'(in_ready),  64'd0);
    endtask

    initial begin
        int sent [NUM_CH];
        logic [NUM_CH-1:0] accepted;

        rst = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        step(); step();
        check_reset_outputs("rst0");
        rst = 1'b0;
        step();
        check("rst0_release_ready", 64'(in_ready), 64'hF);

        // single beat into idle harness
        set_data(2, 32'hA5A5_0002);
        in_valid = 4'b0100;
        step();
        in_valid = '0;
        check("t2_valid_k", 64'(out_valid), 64'd0);
        check("t2_level_k", 64'(level_of(2)), 64'd1);
        step();
        check("t2_valid_k1", 64'(out_valid), 64'd1);
        check("t2_ch", 64'(out_ch), 64'd2);
        check("t2_data", 64'(out_data), 64'hA5A5_0002);
        check("t2_level_k1", 64'(level_of(2)), 64'd0);
        exp_q.push_back({CH_W'(2), 32'hA5A5_0002});
        drain("t2_drain", 10);

        // flush with five beats sitting in the FIFOs
        out_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) set_data(c, DATA_W'(32'h6000_0000 + c));
        in_valid = 4'b1111;
        step();
        in_valid = 4'b0011;
        step();
        in_valid = '0;
        check("t6_queued", 64'(level_sum()), 64'd5);
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        in_valid = 4'b1111;
        step();
        flush = 1'b0;
        in_valid = '0;
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_level", 64'(ch_level), 64'd0);
        check("t6_ready", 64'(in_ready), 64'hF);
        step();
        check("t6_discard_valid", 64'(out_valid), 64'd0);
        check("t6_discard_level", 64'(ch_level), 64'd0);

        // four channels, eight beats each, strict rotation from channel 0
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < NUM_CH; c++)
                exp_q.push_back({CH_W'(c), rr_beat(c, r)});
        for (int c = 0; c < NUM_CH; c++) sent[c] = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                in_valid[c] = (sent[c] < 8);
                set_data(c, rr_beat(c, sent[c]));
            end
            if (out_valid) check("t3_beat", 64'({out_ch, out_data}), 64'(exp_q.pop_front()));
            accepted = in_valid & in_ready;
            step();
            for (int c = 0; c < NUM_CH; c++) if (accepted[c]) sent[c]++;
        end
        in_valid = '0;
        check("t3_left", 64'(exp_q.size()), 64'd0);
        check("t3_sent", 64'(sent[0] + sent[1] + sent[2] + sent[3]), 64'd32);
        exp_q.delete();

        // backpressure on channel 1 until its FIFO is full
        out_ready = 1'b0;
        in_valid = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            set_data(1, DATA_W'(32'h4000_0000 + i));
            step();
        end
        check("t4_level7", 64'(level_of(1)), 64'd7);
        check("t4_ready7", 64'(in_ready[1]), 64'd1);
        check("t4_head", 64'(out_data), 64'h4000_0000);
        check("t4_head_ch", 64'(out_ch), 64'd1);
        set_data(1, 32'h4000_0008);
        step();
        check("t4_level8", 64'(level_of(1)), 64'd8);
        check("t4_full", 64'(in_ready[1]), 64'd0);
        set_data(1, 32'h4000_0009);
        step();
        in_valid = '0;
        check("t4_no_overwrite", 64'(level_of(1)), 64'd8);
        check("t4_hold", 64'(out_data), 64'h4000_0000);
        check("t4_no_tmo", 64'(timeout), 64'd0);
        for (int i = 0; i < 9; i++) exp_q.push_back({CH_W'(1), DATA_W'(32'h4000_0000 + i)});
        drain("t4_drain", 30);

        // watchdog with TIMEOUT=16
        out_ready = 1'b0;
        set_data(0, 32'h5555_0000);
        in_valid = 4'b0001;
        step();
        in_valid = '0;
        step();
        check("t5_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 14; i++) step();
        check("t5_early", 64'(timeout), 64'd0);
        for (int i = 0; i < 4; i++) step();
        check("t5_fired", 64'(timeout), 64'd1);
        out_ready = 1'b1;
        step(); step();
        check("t5_sticky_ready", 64'(timeout), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_sticky_flush", 64'(timeout), 64'd1);

        // reset asserted mid-traffic, away from a clock edge
        out_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) set_data(c, DATA_W'(32'h7000_0000 + c));
        in_valid = 4'b1111;
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst1");
        in_valid = '0;
        step();
        rst = 1'b0;
        step();
        check("rst1_release_ready", 64'(in_ready), 64'hF);
        check("rst1_release_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
